// File: rtl/wave_analyzer.sv
// Period and min/max analyzer for the signal_generator output stream.
// Measures samples between rising threshold crossings and strobes out each result.
module wave_analyzer #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned THRESH = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       wave_choise,
    input  logic [WIDTH-1:0] wave,
    output logic [CNT_W-1:0] period,
    output logic [WIDTH-1:0] wave_max,
    output logic [WIDTH-1:0] wave_min,
    output logic             meas_valid,
    output logic             meas_stb,
    output logic             overflow
);

    localparam int unsigned     CMAX   = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] CMAX_V = CNT_W'(CMAX);
    localparam logic [WIDTH-1:0] THR_V  = WIDTH'(THRESH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] count, count_nxt;
    logic [WIDTH-1:0] run_min, run_min_nxt;
    logic [WIDTH-1:0] run_max, run_max_nxt;
    logic [CNT_W-1:0] period_nxt;
    logic [WIDTH-1:0] wave_max_nxt, wave_min_nxt;
    logic             meas_valid_nxt, meas_stb_nxt, overflow_nxt;

    logic crossing_c;
    logic sel_chg_c;

    assign crossing_c = (prev < THR_V) && (wave >= THR_V);
    assign sel_chg_c  = (wave_choise != sel_q);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev       <= '0;
            sel_q      <= wave_choise;
            count      <= '0;
            run_min    <= '0;
            run_max    <= '0;
            period     <= '0;
            wave_max   <= '0;
            wave_min   <= '0;
            meas_valid <= 1'b0;
            meas_stb   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev       <= wave;
            sel_q      <= wave_choise;
            count      <= count_nxt;
            run_min    <= run_min_nxt;
            run_max    <= run_max_nxt;
            period     <= period_nxt;
            wave_max   <= wave_max_nxt;
            wave_min   <= wave_min_nxt;
            meas_valid <= meas_valid_nxt;
            meas_stb   <= meas_stb_nxt;
            overflow   <= overflow_nxt;
        end
    end

    // Next-state and measurement logic; a select change overrides everything
    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        run_min_nxt    = run_min;
        run_max_nxt    = run_max;
        period_nxt     = period;
        wave_max_nxt   = wave_max;
        wave_min_nxt   = wave_min;
        meas_valid_nxt = meas_valid;
        meas_stb_nxt   = 1'b0;
        overflow_nxt   = overflow;

        if (sel_chg_c) begin
            meas_valid_nxt = 1'b0;
            overflow_nxt   = 1'b0;
            state_nxt      = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = ARM;
                ARM: begin
                    if (crossing_c) begin
                        count_nxt   = CNT_W'(1);
                        run_min_nxt = wave;
                        run_max_nxt = wave;
                        state_nxt   = MEASURE;
                    end
                end
                MEASURE: begin
                    if (crossing_c) begin
                        period_nxt     = count;
                        wave_min_nxt   = run_min;
                        wave_max_nxt   = run_max;
                        meas_stb_nxt   = 1'b1;
                        meas_valid_nxt = 1'b1;
                        overflow_nxt   = 1'b0;
                        count_nxt      = CNT_W'(1);
                        run_min_nxt    = wave;
                        run_max_nxt    = wave;
                    end else if (count != CMAX_V) begin
                        count_nxt = count + CNT_W'(1);
                        if (wave < run_min) run_min_nxt = wave;
                        if (wave > run_max) run_max_nxt = wave;
                    end else begin
                        overflow_nxt   = 1'b1;
                        meas_valid_nxt = 1'b0;
                        state_nxt      = ARM;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_analyzer.sv
// Self-checking bench for wave_analyzer: directed scenarios plus randomized
// streams, compared every cycle against a timestamp-based reference model.
module tb_wave_analyzer;

    localparam int THRESH = 16;
    localparam int CMAX   = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] wave_choise = 2'd0;
    logic [4:0] wave = 5'd0;
    logic [7:0] period;
    logic [4:0] wave_max, wave_min;
    logic       meas_valid, meas_stb, overflow;

    always #5 clk = ~clk;

    wave_analyzer #(.WIDTH(5), .THRESH(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .wave_choise(wave_choise),
        .wave       (wave),
        .period     (period),
        .wave_max   (wave_max),
        .wave_min   (wave_min),
        .meas_valid (meas_valid),
        .meas_stb   (meas_stb),
        .overflow   (overflow)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: crossings are timestamped; a period is the gap between
    // two evaluated crossings, the window is the list of samples in between.
    int         t = 0;
    int         eval_from = 0;
    int         last_cross = -1;
    int         win[$];
    int         m_prev = 0;
    logic [1:0] m_sel = 2'd0;
    logic [7:0] m_period = '0;
    logic [4:0] m_max = '0, m_min = '0;
    logic       m_valid = 1'b0, m_stb = 1'b0, m_ovf = 1'b0;

    function automatic logic [20:0] dut_o();
        return {period, wave_max, wave_min, meas_valid, meas_stb, overflow};
    endfunction

    function automatic logic [20:0] mdl_o();
        return {m_period, m_max, m_min, m_valid, m_stb, m_ovf};
    endfunction

    task automatic model_step(input logic r, input logic [1:0] s, input int w);
        int mn, mx;
        t++;
        m_stb = 1'b0;
        if (r) begin
            m_period = '0; m_max = '0; m_min = '0;
            m_valid = 1'b0; m_ovf = 1'b0;
            m_prev = 0; m_sel = s;
            last_cross = -1; win.delete();
            eval_from = t + 2;
            return;
        end
        if (s != m_sel) begin
            m_valid = 1'b0; m_ovf = 1'b0;
            last_cross = -1;
            eval_from = t + 2;
        end else if (t >= eval_from) begin
            if (m_prev < THRESH && w >= THRESH) begin
                if (last_cross >= 0) begin
                    mn = 1000; mx = -1;
                    foreach (win[i]) begin
                        if (win[i] < mn) mn = win[i];
                        if (win[i] > mx) mx = win[i];
                    end
                    m_period = 8'(t - last_cross);
                    m_min = 5'(mn); m_max = 5'(mx);
                    m_stb = 1'b1; m_valid = 1'b1; m_ovf = 1'b0;
                end
                last_cross = t;
                win.delete();
                win.push_back(w);
            end else if (last_cross >= 0) begin
                if (t - last_cross == CMAX) begin
                    m_ovf = 1'b1; m_valid = 1'b0;
                    last_cross = -1;
                end else begin
                    win.push_back(w);
                end
            end
        end
        m_prev = w;
        m_sel = s;
    endtask

    task automatic drive_cycle(input logic r, input logic [1:0] s, input int w);
        rst = r;
        wave_choise = s;
        wave = 5'(w);
        @(posedge clk);
        model_step(r, s, w);
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 2'd0, 7);
        drive_cycle(1'b1, 2'd0, 9);
        tests++;
        if (dut_o() !== 21'd0)
            $display("FAIL reset_outputs got=%h exp=0", dut_o());
        drive_cycle(1'b0, 2'd0, 20);
        tests++;
        if (dut_o() !== mdl_o())
            $display("FAIL reset_idle got=%h exp=%h", dut_o(), mdl_o());
    endtask

    task automatic test_square();
        int strobes = 0;
        drive_cycle(1'b1, 2'd0, 0);
        for (int i = 0; i < 100; i++) begin
            drive_cycle(1'b0, 2'd0, ((i / 10) % 2) != 0 ? 31 : 0);
            tests++;
            if (dut_o() !== mdl_o()) begin
                fails++;
                $display("FAIL square_cycle i=%0d got=%h exp=%h", i, dut_o(), mdl_o());
            end
            if (meas_stb === 1'b1) begin
                strobes++;
                tests++;
                if ({period, wave_max, wave_min, meas_valid} !== {8'd20, 5'd31, 5'd0, 1'b1}) begin
                    fails++;
                    $display("FAIL square_result i=%0d got=%0d/%0d/%0d/%b exp=20/31/0/1",
                             i, period, wave_max, wave_min, meas_valid);
                end
            end
        end
        tests++;
        if (strobes != 4) begin
            fails++;
            $display("FAIL square_strobes got=%0d exp=4", strobes);
        end
    endtask

    task automatic test_ramp();
        int strobes = 0;
        drive_cycle(1'b1, 2'd0, 0);
        for (int i = 0; i < 140; i++) begin
            drive_cycle(1'b0, 2'd0, i % 32);
            tests++;
            if (dut_o() !== mdl_o()) begin
                fails++;
                $display("FAIL ramp_cycle i=%0d got=%h exp=%h", i, dut_o(), mdl_o());
            end
            if (meas_stb === 1'b1) begin
                strobes++;
                tests++;
                if ({period, wave_max, wave_min} !== {8'd32, 5'd31, 5'd0}) begin
                    fails++;
                    $display("FAIL ramp_result i=%0d got=%0d/%0d/%0d exp=32/31/0",
                             i, period, wave_max, wave_min);
                end
            end
        end
        tests++;
        if (strobes != 3) begin
            fails++;
            $display("FAIL ramp_strobes got=%0d exp=3", strobes);
        end
    endtask

    task automatic test_threshold();
        int strobes = 0;
        drive_cycle(1'b1, 2'd0, 0);
        for (int i = 0; i < 80; i++) begin
            drive_cycle(1'b0, 2'd0, ((i / 4) % 2) != 0 ? 16 : 15);
            tests++;
            if (dut_o() !== mdl_o()) begin
                fails++;
                $display("FAIL thresh_cycle i=%0d got=%h exp=%h", i, dut_o(), mdl_o());
            end
            if (meas_stb === 1'b1) begin
                strobes++;
                tests++;
                if ({period, wave_max, wave_min} !== {8'd8, 5'd16, 5'd15}) begin
                    fails++;
                    $display("FAIL thresh_result i=%0d got=%0d/%0d/%0d exp=8/16/15",
                             i, period, wave_max, wave_min);
                end
            end
        end
        tests++;
        if (strobes != 9) begin
            fails++;
            $display("FAIL thresh_strobes got=%0d exp=9", strobes);
        end
        strobes = 0;
        drive_cycle(1'b1, 2'd0, 0);
        for (int i = 0; i < 80; i++) begin
            drive_cycle(1'b0, 2'd0, ((i / 4) % 2) != 0 ? 15 : 14);
            if (meas_stb === 1'b1) strobes++;
        end
        tests++;
        if (strobes != 0 || meas_valid !== 1'b0) begin
            fails++;
            $display("FAIL below_thresh got_strobes=%0d valid=%b exp=0/0", strobes, meas_valid);
        end
    endtask

    task automatic test_overflow();
        int strobes = 0;
        drive_cycle(1'b1, 2'd0, 0);
        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'b0, 2'd0, 20);
            if (meas_stb === 1'b1) strobes++;
        end
        tests++;
        if (strobes != 0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL const_no_cross got_strobes=%0d ovf=%b exp=0/0", strobes, overflow);
        end
        drive_cycle(1'b0, 2'd0, 0);
        drive_cycle(1'b0, 2'd0, 20);
        for (int k = 1; k <= 255; k++) begin
            drive_cycle(1'b0, 2'd0, 20);
            if (k == 254) begin
                tests++;
                if (overflow !== 1'b0) begin
                    fails++;
                    $display("FAIL ovf_early got=%b exp=0", overflow);
                end
            end
        end
        tests++;
        if ({overflow, meas_valid} !== 2'b10) begin
            fails++;
            $display("FAIL ovf_set got=%b/%b exp=1/0", overflow, meas_valid);
        end
        for (int i = 0; i < 60; i++) begin
            drive_cycle(1'b0, 2'd0, ((i / 10) % 2) != 0 ? 31 : 0);
            tests++;
            if (dut_o() !== mdl_o()) begin
                fails++;
                $display("FAIL ovf_recover_cycle i=%0d got=%h exp=%h", i, dut_o(), mdl_o());
            end
        end
        tests++;
        if ({overflow, meas_valid, period} !== {1'b0, 1'b1, 8'd20}) begin
            fails++;
            $display("FAIL ovf_clear got=%b/%b/%0d exp=0/1/20", overflow, meas_valid, period);
        end
    endtask

    task automatic test_select_change();
        int first = -1;
        drive_cycle(1'b1, 2'd0, 0);
        for (int i = 0; i < 130; i++) begin
            drive_cycle(1'b0, (i >= 50) ? 2'd1 : 2'd0, ((i / 10) % 2) != 0 ? 31 : 0);
            tests++;
            if (dut_o() !== mdl_o()) begin
                fails++;
                $display("FAIL sel_cycle i=%0d got=%h exp=%h", i, dut_o(), mdl_o());
            end
            if (i == 50) begin
                tests++;
                if ({meas_stb, meas_valid} !== 2'b00) begin
                    fails++;
                    $display("FAIL sel_priority got stb/valid=%b/%b exp=0/0", meas_stb, meas_valid);
                end
            end
            if (i > 50 && first < 0 && meas_stb === 1'b1) first = i;
        end
        tests++;
        if (first != 90) begin
            fails++;
            $display("FAIL sel_first_strobe got=%0d exp=90", first);
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        drive_cycle(1'b1, 2'd0, 0);
        for (int i = 0; i < 130; i++) begin
            drive_cycle(i == 45, 2'd0, ((i / 10) % 2) != 0 ? 31 : 0);
            tests++;
            if (dut_o() !== mdl_o()) begin
                fails++;
                $display("FAIL rstmid_cycle i=%0d got=%h exp=%h", i, dut_o(), mdl_o());
            end
            if (i == 45) begin
                tests++;
                if (dut_o() !== 21'd0) begin
                    fails++;
                    $display("FAIL rstmid_zero got=%h exp=0", dut_o());
                end
            end
            if (i > 45 && first < 0 && meas_stb === 1'b1) first = i;
        end
        tests++;
        if (first != 70 || period !== 8'd20) begin
            fails++;
            $display("FAIL rstmid_resume got=%0d/%0d exp=70/20", first, period);
        end
    endtask

    task automatic test_random();
        int seg_left = 0, kind = 0, lo = 1, hi = 1, ph = 0, cval = 0, w;
        logic r;
        logic [1:0] s = wave_choise;
        for (int c = 0; c < 4000; c++) begin
            if (seg_left == 0) begin
                kind = int'($urandom_range(0, 2));
                seg_left = (kind == 1) ? int'($urandom_range(260, 300)) : int'($urandom_range(50, 400));
                lo = int'($urandom_range(1, 60));
                hi = int'($urandom_range(1, 60));
                ph = 0;
                cval = int'($urandom_range(0, 31));
            end
            case (kind)
                0: begin
                    w = (ph < lo) ? int'($urandom_range(0, 15)) : int'($urandom_range(16, 31));
                    ph = (ph + 1) % (lo + hi);
                end
                1: w = cval;
                default: w = int'($urandom_range(0, 31));
            endcase
            seg_left--;
            r = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 199) == 0) s = 2'($urandom_range(0, 3));
            drive_cycle(r, s, w);
            tests++;
            if (dut_o() !== mdl_o()) begin
                fails++;
                $display("FAIL random_cycle c=%0d got=%h exp=%h", c, dut_o(), mdl_o());
            end
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_ramp();
        test_threshold();
        test_overflow();
        test_select_change();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
